// File: rtl/median_window_ctrl_pkg.sv
// Shared types and constants for the binary 3x3 median window controller.
// Package median_pkg is imported by median_tap_gen and median_window_ctrl.
package median_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } medState_e;

    localparam int TAP_COUNT          = 9;
    localparam int MAJORITY_THRESHOLD = 5;
    localparam int DEFAULT_IMWIDTH    = 240;
    localparam int DEFAULT_IMHEIGHT   = 180;

    localparam logic [3:0] LAST_TAP = 4'(TAP_COUNT - 1);

    // Binary median of nine samples: set when ones are the majority.
    function automatic logic isMajority(input logic [3:0] ones);
        return (ones >= 4'(MAJORITY_THRESHOLD));
    endfunction

endpackage

// File: rtl/median_window_ctrl_if.sv
// Pixel-memory read port and filtered-pixel valid/ready stream of the median controller.
interface median_window_ctrl_if;

    logic [7:0] memXAddr;
    logic [7:0] memYAddr;
    logic       memDataIn;
    logic       outValid;
    logic       outReady;
    logic [7:0] outX;
    logic [7:0] outY;
    logic       outPixel;

    modport master (
        output memXAddr,
        output memYAddr,
        input  memDataIn,
        output outValid,
        input  outReady,
        output outX,
        output outY,
        output outPixel
    );

    modport slave (
        input  memXAddr,
        input  memYAddr,
        output memDataIn,
        input  outValid,
        output outReady,
        input  outX,
        input  outY,
        input  outPixel
    );

endinterface

// File: rtl/median_window_ctrl_tap_gen.sv
// Maps centre pixel (x, y) and tap index k to a clamped neighbour address
// (x + k/3 - 1, y + k%3 - 1) plus a flag telling whether clamping was needed.
module median_tap_gen
    import median_pkg::*;
#(
    parameter int IMWIDTH  = DEFAULT_IMWIDTH,
    parameter int IMHEIGHT = DEFAULT_IMHEIGHT
) (
    input  logic [7:0] centerX,
    input  logic [7:0] centerY,
    input  logic [3:0] tapK,
    output logic [7:0] tapX,
    output logic [7:0] tapY,
    output logic       tapInRange
);

    logic [1:0] colSel_s;
    logic [1:0] rowSel_s;
    logic [9:0] rawX_s;
    logic [9:0] rawY_s;
    logic       xOk_s;
    logic       yOk_s;

    // Tap index to column/row offset selectors (offset = selector - 1).
    always_comb begin
        colSel_s = 2'd1;
        rowSel_s = 2'd1;
        case (tapK)
            4'd0: begin colSel_s = 2'd0; rowSel_s = 2'd0; end
            4'd1: begin colSel_s = 2'd0; rowSel_s = 2'd1; end
            4'd2: begin colSel_s = 2'd0; rowSel_s = 2'd2; end
            4'd3: begin colSel_s = 2'd1; rowSel_s = 2'd0; end
            4'd4: begin colSel_s = 2'd1; rowSel_s = 2'd1; end
            4'd5: begin colSel_s = 2'd1; rowSel_s = 2'd2; end
            4'd6: begin colSel_s = 2'd2; rowSel_s = 2'd0; end
            4'd7: begin colSel_s = 2'd2; rowSel_s = 2'd1; end
            4'd8: begin colSel_s = 2'd2; rowSel_s = 2'd2; end
            default: begin colSel_s = 2'd1; rowSel_s = 2'd1; end
        endcase
    end

    // Clamp to the image; bit 9 of the raw sum only sets when x/y = 0 steps left/up.
    always_comb begin
        rawX_s = {2'b00, centerX} + {8'b0000_0000, colSel_s} - 10'd1;
        rawY_s = {2'b00, centerY} + {8'b0000_0000, rowSel_s} - 10'd1;

        if (rawX_s[9]) begin
            tapX  = 8'd0;
            xOk_s = 1'b0;
        end else if (rawX_s > 10'(IMWIDTH - 1)) begin
            tapX  = 8'(IMWIDTH - 1);
            xOk_s = 1'b0;
        end else begin
            tapX  = rawX_s[7:0];
            xOk_s = 1'b1;
        end

        if (rawY_s[9]) begin
            tapY  = 8'd0;
            yOk_s = 1'b0;
        end else if (rawY_s > 10'(IMHEIGHT - 1)) begin
            tapY  = 8'(IMHEIGHT - 1);
            yOk_s = 1'b0;
        end else begin
            tapY  = rawY_s[7:0];
            yOk_s = 1'b1;
        end

        tapInRange = xOk_s & yOk_s;
    end

endmodule

// File: rtl/median_window_ctrl.sv
// Binary 3x3 median filter controller: walks the image x-outer/y-inner, reads nine taps per
// pixel and streams the majority result. Define MEDIAN_BORDER_REPLICATE_EN for edge replication.
module median_window_ctrl
    import median_pkg::*;
#(
    parameter int IMWIDTH      = DEFAULT_IMWIDTH,
    parameter int IMHEIGHT     = DEFAULT_IMHEIGHT,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    median_window_ctrl_if.master bus
);

`ifdef MEDIAN_BORDER_REPLICATE_EN
    localparam logic REPLICATE_BORDER = 1'b1;
`else
    localparam logic REPLICATE_BORDER = 1'b0;
`endif

    medState_e state_r;
    medState_e nextState_s;

    logic [7:0] pixX_r;
    logic [7:0] pixY_r;
    logic [3:0] tapK_r;
    logic [7:0] drainCnt_r;
    logic [7:0] nextX_s;
    logic [7:0] nextY_s;
    logic [3:0] nextK_s;
    logic [7:0] nextDrain_s;

    logic [3:0] count_r;
    logic [3:0] countNext_s;

    logic [7:0] tapX_s;
    logic [7:0] tapY_s;
    logic       tapInRange_s;

    logic       issueFlag_r;
    logic       inRangeFlag_r;
    logic [READ_LATENCY-1:0] validPipe_r;
    logic [READ_LATENCY-1:0] rangePipe_r;
    logic       sampleBit_s;

    logic       busy_r;
    logic       done_r;
    logic       outValid_r;
    logic       outPixel_r;
    logic [7:0] outX_r;
    logic [7:0] outY_r;
    logic [7:0] memXAddr_r;
    logic [7:0] memYAddr_r;

    logic       transfer_s;
    logic       lastPixel_s;

    assign transfer_s  = (state_r == ST_EMIT) && outValid_r && bus.outReady;
    assign lastPixel_s = (pixX_r == 8'(IMWIDTH - 1)) && (pixY_r == 8'(IMHEIGHT - 1));

    // Taps are generated for the coming cycle so the address register lines up with ISSUE.
    median_tap_gen #(
        .IMWIDTH  (IMWIDTH),
        .IMHEIGHT (IMHEIGHT)
    ) u_tapGen (
        .centerX    (nextX_s),
        .centerY    (nextY_s),
        .tapK       (nextK_s),
        .tapX       (tapX_s),
        .tapY       (tapY_s),
        .tapInRange (tapInRange_s)
    );

    // Next-state and next-position logic.
    always_comb begin
        nextState_s = state_r;
        nextX_s     = pixX_r;
        nextY_s     = pixY_r;
        nextK_s     = tapK_r;
        nextDrain_s = drainCnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    nextState_s = ST_ISSUE;
                    nextX_s     = 8'd0;
                    nextY_s     = 8'd0;
                    nextK_s     = 4'd0;
                end else begin
                    nextState_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (tapK_r == LAST_TAP) begin
                    nextState_s = ST_DRAIN;
                    nextK_s     = 4'd0;
                    nextDrain_s = 8'd1;
                end else begin
                    nextK_s = tapK_r + 4'd1;
                end
            end
            ST_DRAIN: begin
                if (drainCnt_r == 8'(READ_LATENCY)) begin
                    nextState_s = ST_EMIT;
                end else begin
                    nextDrain_s = drainCnt_r + 8'd1;
                end
            end
            ST_EMIT: begin
                if (transfer_s) begin
                    if (lastPixel_s) begin
                        nextState_s = ST_DONE;
                    end else begin
                        nextState_s = ST_ISSUE;
                        nextK_s     = 4'd0;
                        if (pixY_r == 8'(IMHEIGHT - 1)) begin
                            nextY_s = 8'd0;
                            nextX_s = pixX_r + 8'd1;
                        end else begin
                            nextY_s = pixY_r + 8'd1;
                        end
                    end
                end else begin
                    nextState_s = ST_EMIT;
                end
            end
            ST_DONE: begin
                nextState_s = ST_IDLE;
            end
            default: begin
                nextState_s = ST_IDLE;
            end
        endcase
    end

    // A sample counts when its tap was issued; out-of-range taps count only when replicating.
    always_comb begin
        sampleBit_s = validPipe_r[READ_LATENCY-1] & bus.memDataIn
                      & (rangePipe_r[READ_LATENCY-1] | REPLICATE_BORDER);
        countNext_s = count_r;
        if ((state_r != ST_ISSUE) && (nextState_s == ST_ISSUE)) begin
            countNext_s = 4'd0;
        end else if (sampleBit_s) begin
            countNext_s = count_r + 4'd1;
        end else begin
            countNext_s = count_r;
        end
    end

    // FSM state, scan position, tap/drain counters and ones count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            pixX_r     <= 8'd0;
            pixY_r     <= 8'd0;
            tapK_r     <= 4'd0;
            drainCnt_r <= 8'd0;
            count_r    <= 4'd0;
        end else begin
            state_r    <= nextState_s;
            pixX_r     <= nextX_s;
            pixY_r     <= nextY_s;
            tapK_r     <= nextK_s;
            drainCnt_r <= nextDrain_s;
            count_r    <= countNext_s;
        end
    end

    // Per-tap issue and in-range flags delayed to meet the returning memory data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issueFlag_r   <= 1'b0;
            inRangeFlag_r <= 1'b0;
            validPipe_r   <= '0;
            rangePipe_r   <= '0;
        end else begin
            issueFlag_r    <= (nextState_s == ST_ISSUE);
            inRangeFlag_r  <= (nextState_s == ST_ISSUE) && tapInRange_s;
            validPipe_r[0] <= issueFlag_r;
            rangePipe_r[0] <= inRangeFlag_r;
            for (int i = 1; i < READ_LATENCY; i++) begin
                validPipe_r[i] <= validPipe_r[i-1];
                rangePipe_r[i] <= rangePipe_r[i-1];
            end
        end
    end

    // Registered status, memory address and output-stream signals.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            outValid_r <= 1'b0;
            outX_r     <= 8'd0;
            outY_r     <= 8'd0;
            outPixel_r <= 1'b0;
            memXAddr_r <= 8'd0;
            memYAddr_r <= 8'd0;
        end else begin
            busy_r     <= (nextState_s == ST_ISSUE) || (nextState_s == ST_DRAIN)
                          || (nextState_s == ST_EMIT);
            done_r     <= (nextState_s == ST_DONE);
            outValid_r <= (nextState_s == ST_EMIT);
            if ((state_r == ST_DRAIN) && (nextState_s == ST_EMIT)) begin
                outX_r     <= pixX_r;
                outY_r     <= pixY_r;
                outPixel_r <= isMajority(countNext_s);
            end
            if (nextState_s == ST_ISSUE) begin
                memXAddr_r <= tapX_s;
                memYAddr_r <= tapY_s;
            end else begin
                memXAddr_r <= 8'd0;
                memYAddr_r <= 8'd0;
            end
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign bus.outValid = outValid_r;
    assign bus.outX     = outX_r;
    assign bus.outY     = outY_r;
    assign bus.outPixel = outPixel_r;
    assign bus.memXAddr = memXAddr_r;
    assign bus.memYAddr = memYAddr_r;

endmodule

// File: tb/tb_median_window_ctrl.sv
// Self-checking bench for median_window_ctrl on a reduced 16x12 image with a
// behavioural 3x3 majority model; honours MEDIAN_BORDER_REPLICATE_EN when defined.
module tb_median_window_ctrl;

    localparam int W        = 16;
    localparam int H        = 12;
    localparam int RL       = 1;
    localparam int N        = W * H;
    localparam int PIX_CYC  = 10 + RL;
    localparam int BUDGET   = N * PIX_CYC * 2 + 200;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;

    median_window_ctrl_if bus ();

    median_window_ctrl #(
        .IMWIDTH      (W),
        .IMHEIGHT     (H),
        .READ_LATENCY (RL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit img    [W][H];
    bit dutOut [W][H];

    // Pixel memory with RL cycles of read latency.
    logic memPipe [RL];
    always @(posedge clk) begin
        if (int'(bus.memXAddr) < W && int'(bus.memYAddr) < H)
            memPipe[0] <= img[int'(bus.memXAddr)][int'(bus.memYAddr)];
        else
            memPipe[0] <= 1'b0;
        for (int i = 1; i < RL; i++) memPipe[i] <= memPipe[i-1];
    end
    assign bus.memDataIn = memPipe[RL-1];

    int checks = 0;
    int fails  = 0;

    int idx = 0;
    int doneCount = 0;
    int doneCyc = 0;
    int lastXferCyc = 0;
    int firstX = -1;
    int firstY = -1;
    bit fullSpeed = 1'b0;
    bit stallPrev = 1'b0;
    logic [7:0] savedMemX;
    logic [7:0] savedMemY;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: 3x3 majority with zero padding or edge replication.
    function automatic bit modelPixel(input int x, input int y);
        int c = 0;
        for (int dx = -1; dx <= 1; dx++) begin
            for (int dy = -1; dy <= 1; dy++) begin
                int nx = x + dx;
                int ny = y + dy;
                if (nx >= 0 && nx < W && ny >= 0 && ny < H) begin
                    c += int'(img[nx][ny]);
                end else begin
`ifdef MEDIAN_BORDER_REPLICATE_EN
                    int cx = (nx < 0) ? 0 : ((nx >= W) ? W - 1 : nx);
                    int cy = (ny < 0) ? 0 : ((ny >= H) ? H - 1 : ny);
                    c += int'(img[cx][cy]);
`endif
                end
            end
        end
        return (c >= 5);
    endfunction

    // Per-cycle compare against the model, sampled on the falling edge.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!reset) begin
                idx       = 0;
                stallPrev = 1'b0;
                continue;
            end
            if (start && !busy) begin
                idx    = 0;
                firstX = -1;
                firstY = -1;
            end
            chk("addr_in_range", int'(int'(bus.memXAddr) < W && int'(bus.memYAddr) < H), 1);
            if (stallPrev) begin
                chk("stall_valid_held", int'(bus.outValid), 1);
                chk("stall_memx_held", int'(bus.memXAddr), int'(savedMemX));
                chk("stall_memy_held", int'(bus.memYAddr), int'(savedMemY));
            end
            stallPrev = bus.outValid && !bus.outReady;
            savedMemX = bus.memXAddr;
            savedMemY = bus.memYAddr;
            if (bus.outValid) begin
                if (idx >= N) begin
                    chk("extra_output", idx, N - 1);
                end else begin
                    chk("out_x", int'(bus.outX), idx / H);
                    chk("out_y", int'(bus.outY), idx % H);
                    chk("out_pixel", int'(bus.outPixel), int'(modelPixel(idx / H, idx % H)));
                    chk("busy_in_emit", int'(busy), 1);
                    if (bus.outReady) begin
                        if (idx == 0) begin
                            firstX = int'(bus.outX);
                            firstY = int'(bus.outY);
                        end
                        if (fullSpeed && idx > 0) chk("pixel_period", cyc - lastXferCyc, PIX_CYC);
                        lastXferCyc = cyc;
                        if (int'(bus.outX) < W && int'(bus.outY) < H)
                            dutOut[int'(bus.outX)][int'(bus.outY)] = bus.outPixel;
                        idx++;
                    end
                end
            end
            if (done) begin
                doneCount++;
                doneCyc = cyc;
                chk("done_after_last", idx, N);
                chk("busy_low_at_done", int'(busy), 0);
            end
        end
    endtask

    task automatic fillImg(input bit v);
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++) img[x][y] = v;
    endtask

    // Run one frame; optional mid-frame start pulse and a 20-cycle outReady stall.
    task automatic runFrame(input string tag, input bit midStart, input int stallAt);
        int d0 = doneCount;
        int startCyc;
        int stallCnt = 0;
        bit stallDone = 1'b0;
        bit finished = 1'b0;
        fullSpeed = (stallAt < 0);
        @(posedge clk); #1;
        start = 1'b1;
        startCyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            if (doneCount > d0) begin
                finished = 1'b1;
                break;
            end
            start = (midStart && i == 300) ? 1'b1 : 1'b0;
            if (stallCnt > 0) begin
                stallCnt--;
                if (stallCnt == 0) bus.outReady = 1'b1;
            end else if (!stallDone && stallAt >= 0 && idx >= stallAt && bus.outValid) begin
                bus.outReady = 1'b0;
                stallCnt = 20;
                stallDone = 1'b1;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        bus.outReady = 1'b1;
        chk({tag, "_frame_finished"}, int'(finished), 1);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_once"}, doneCount - d0, 1);
        chk({tag, "_idle_busy"}, int'(busy), 0);
        chk({tag, "_idle_valid"}, int'(bus.outValid), 0);
        chk({tag, "_idle_memx"}, int'(bus.memXAddr), 0);
        chk({tag, "_idle_memy"}, int'(bus.memYAddr), 0);
        if (fullSpeed && finished) begin
            checks++;
            if ((doneCyc - startCyc) < N * PIX_CYC - 2 || (doneCyc - startCyc) > N * PIX_CYC + 2) begin
                fails++;
                $display("FAIL %s_frame_len: got %0d cycles, expected %0d +/-2", tag,
                         doneCyc - startCyc, N * PIX_CYC);
            end
        end
    endtask

    task automatic chkResetOutputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_valid"}, int'(bus.outValid), 0);
        chk({tag, "_outx"}, int'(bus.outX), 0);
        chk({tag, "_outy"}, int'(bus.outY), 0);
        chk({tag, "_pixel"}, int'(bus.outPixel), 0);
        chk({tag, "_memx"}, int'(bus.memXAddr), 0);
        chk({tag, "_memy"}, int'(bus.memYAddr), 0);
    endtask

    initial begin
        int d0;
        bit reached;
        bus.outReady = 1'b1;
        fillImg(1'b0);
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chkResetOutputs("reset");
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // All-zero image at full speed.
        runFrame("zero", 1'b0, -1);
        chk("zero_corner", int'(dutOut[0][0]), 0);
        chk("zero_interior", int'(dutOut[7][5]), 0);

        // All-one image with a start pulse while busy.
        fillImg(1'b1);
`ifdef MEDIAN_BORDER_REPLICATE_EN
        chk("model_ones_corner", int'(modelPixel(0, 0)), 1);
        runFrame("ones", 1'b1, -1);
        chk("ones_corner00", int'(dutOut[0][0]), 1);
        chk("ones_cornerWH", int'(dutOut[W-1][H-1]), 1);
        chk("ones_edge", int'(dutOut[0][5]), 1);
`else
        chk("model_ones_corner", int'(modelPixel(0, 0)), 0);
        chk("model_ones_edge", int'(modelPixel(0, 5)), 1);
        runFrame("ones", 1'b1, -1);
        chk("ones_corner00", int'(dutOut[0][0]), 0);
        chk("ones_corner0H", int'(dutOut[0][H-1]), 0);
        chk("ones_cornerW0", int'(dutOut[W-1][0]), 0);
        chk("ones_cornerWH", int'(dutOut[W-1][H-1]), 0);
        chk("ones_edge_left", int'(dutOut[0][5]), 1);
        chk("ones_edge_top", int'(dutOut[7][0]), 1);
`endif
        chk("ones_interior", int'(dutOut[7][5]), 1);

        // Isolated single one.
        fillImg(1'b0);
        img[10][10] = 1'b1;
        chk("model_single", int'(modelPixel(10, 10)), 0);
        runFrame("single", 1'b0, -1);
        chk("single_centre", int'(dutOut[10][10]), 0);

        // Plus shape centred at (10,10), with a 20-cycle stall at pixel 30.
        img[9][10] = 1'b1;
        img[11][10] = 1'b1;
        img[10][9] = 1'b1;
        img[10][11] = 1'b1;
        chk("model_plus_centre", int'(modelPixel(10, 10)), 1);
        chk("model_plus_arm", int'(modelPixel(10, 9)), 0);
        runFrame("plus", 1'b0, 30);
        chk("plus_centre", int'(dutOut[10][10]), 1);
        chk("plus_arm", int'(dutOut[10][9]), 0);
        chk("plus_diag", int'(dutOut[9][9]), 0);

        // Pseudo-random image.
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++) img[x][y] = 1'($urandom_range(0, 1));
        runFrame("random", 1'b0, -1);

        // Reset during ISSUE of pixel (5,7), then restart from (0,0).
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            if (idx == 5 * H + 7) begin
                reached = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("reach_pixel_5_7", int'(reached), 1);
        repeat (4) @(posedge clk);
        #1;
        chk("centre_tap_memx", int'(bus.memXAddr), 5);
        chk("centre_tap_memy", int'(bus.memYAddr), 7);
        chk("busy_mid_frame", int'(busy), 1);
        d0 = doneCount;
        #2;
        reset = 1'b0;
        #1;
        chkResetOutputs("async_reset");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("no_done_after_abort", doneCount - d0, 0);
        chk("idle_after_abort", int'(busy), 0);
        runFrame("restart", 1'b0, -1);
        chk("restart_first_x", firstX, 0);
        chk("restart_first_y", firstY, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/median_window_ctrl.md
MEDIAN_WINDOW_CTRL -- requirements
Module: median_window_ctrl

Interface
REQ-001 SHALL have parameter IMWIDTH, default 240, meaning image columns (x range 0..IMWIDTH-1).
REQ-002 SHALL have parameter IMHEIGHT, default 180, meaning image rows (y range 0..IMHEIGHT-1).
REQ-003 SHALL have parameter READ_LATENCY, default 1, meaning clk cycles from memory address to memory data.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins one frame filter pass.
REQ-007 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-008 SHALL have port done  output  1  one-cycle pulse after the last output handshake.
REQ-009 SHALL have port memXAddr  output  8  column address to the pixel memory.
REQ-010 SHALL have port memYAddr  output  8  row address to the pixel memory.
REQ-011 SHALL have port memDataIn  input  1  pixel read from the memory, valid READ_LATENCY cycles after the address.
REQ-012 SHALL have port outValid, outReady, outX[7:0], outY[7:0], outPixel  output/input/output/output/output  1/1/8/8/1  filtered-pixel stream with valid/ready handshake.

Function
REQ-013 SHALL scan output pixels x outer (0..IMWIDTH-1), y inner (0..IMHEIGHT-1).
REQ-014 SHALL use FSM IDLE -> ISSUE -> DRAIN -> EMIT -> (ISSUE for next pixel | DONE) -> IDLE.
REQ-015 SHALL leave IDLE only on start=1; start while busy SHALL be ignored.
REQ-016 ISSUE SHALL last 9 cycles, tap k=0..8 addressing (x+k/3-1, y+k%3-1).
REQ-017 Neighbour coordinates SHALL be clamped to 0..IMWIDTH-1 / 0..IMHEIGHT-1 on memXAddr/memYAddr; no out-of-range address is ever driven.
REQ-018 Sample for tap k SHALL be captured READ_LATENCY cycles after issue, using a per-tap in-range flag delayed by the same amount.
REQ-019 DRAIN SHALL last READ_LATENCY cycles so all 9 samples are accumulated into a 4-bit ones count (0..9).
REQ-020 outPixel SHALL be 1 iff count >= 5 (binary 3x3 median).
REQ-021 EMIT SHALL assert outValid with stable outX/outY/outPixel until outReady=1; transfer occurs on outValid&outReady.
REQ-022 After the transfer at (IMWIDTH-1, IMHEIGHT-1), FSM SHALL enter DONE, pulse done for one cycle, drop busy, return to IDLE.
REQ-023 With outReady held 1, each pixel SHALL take exactly 10+READ_LATENCY cycles (11 at default).
REQ-024 In IDLE and DONE, memXAddr/memYAddr SHALL be 0 and outValid 0.

Reset
REQ-025 reset=0 SHALL asynchronously force IDLE, busy=0, done=0, outValid=0, outX=0, outY=0, outPixel=0, memXAddr=0, memYAddr=0, count=0.
REQ-026 reset mid-frame SHALL abandon the frame; no done pulse; a new start after release restarts at (0,0).

Configuration
REQ-027 Macro MEDIAN_BORDER_REPLICATE_EN defined: out-of-range taps SHALL use the clamped-address sample (edge replication).
REQ-028 Macro MEDIAN_BORDER_REPLICATE_EN undefined: out-of-range taps SHALL contribute 0 (zero padding).

Structure
REQ-029 A shared package median_pkg SHALL hold the FSM state enumeration, tap count constant (9), majority threshold (5) and default image dimensions.
REQ-030 One sub-module median_tap_gen SHALL produce clamped tap addresses and the in-range flag from (x, y, k).

Verification
REQ-031 All-zero image, outReady=1 -> 43200 transfers, all outPixel=0, done once, frame length 43200*11 cycles +/-2.
REQ-032 All-one image, zero padding -> corners 0 (count 4), non-corner edges 1 (count 6), interior 1; with MEDIAN_BORDER_REPLICATE_EN all outputs 1.
REQ-033 Single 1 at (10,10), rest 0 -> every outPixel=0; 5-pixel plus centred at (10,10) -> outPixel(10,10)=1.
REQ-034 outReady=0 for 20 cycles during EMIT -> outValid held 1, outX/outY/outPixel unchanged, memory addresses unchanged.
REQ-035 reset=0 at pixel (5,7) mid-ISSUE -> all outputs 0 same cycle; after restart first transfer is (0,0); start pulse while busy -> no effect.
